// File: rtl/gbc_bk_pkg.sv
// gbc_bk_pkg: shared definitions for the cartridge RAM backup controller.
//   - bk_state_t      : backup sequencer states
//   - RAM_SIZE_*      : cartridge header RAM-size codes (byte 0x149)
//   - SECTOR_BYTES    : host sector size in bytes
//   - is_battery_mbc  : header MBC types (byte 0x147) that carry battery-backed RAM
//   - is_mbc2         : MBC2 carts have fixed 512x4-bit internal RAM
package gbc_bk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_NEXT = 2'd3
    } bk_state_t;

    localparam logic [7:0] RAM_SIZE_NONE = 8'd0;
    localparam logic [7:0] RAM_SIZE_2K   = 8'd1;
    localparam logic [7:0] RAM_SIZE_8K   = 8'd2;
    localparam logic [7:0] RAM_SIZE_32K  = 8'd3;
    localparam logic [7:0] RAM_SIZE_128K = 8'd4;

    localparam int SECTOR_BYTES = 512;

    function automatic logic is_battery_mbc(input logic [7:0] mbc_type);
        case (mbc_type)
            8'h03, 8'h06, 8'h09, 8'h0D, 8'h10,
            8'h13, 8'h1B, 8'h1E, 8'h22, 8'hFF: is_battery_mbc = 1'b1;
            default:                           is_battery_mbc = 1'b0;
        endcase
    endfunction

    function automatic logic is_mbc2(input logic [7:0] mbc_type);
        is_mbc2 = (mbc_type == 8'h05) || (mbc_type == 8'h06);
    endfunction

endpackage

// File: rtl/cram_backup_size_decode.sv
// cram_backup_size_decode: combinational decode of the cartridge header into
// the backup geometry.
//   cart_mbc_type [7:0]  in  : header byte 0x147
//   cart_ram_size [7:0]  in  : header byte 0x149
//   last_lba [LBA_W-1:0] out : index of the final 512-byte sector to transfer
//   supported            out : cart has a battery and some RAM to back up
module cram_backup_size_decode
    import gbc_bk_pkg::*;
#(
    parameter int LBA_W = 8
) (
    input  logic [7:0]       cart_mbc_type,
    input  logic [7:0]       cart_ram_size,
    output logic [LBA_W-1:0] last_lba,
    output logic             supported
);

    logic ram_present;

    always_comb begin
        last_lba    = '0;
        ram_present = 1'b1;
        // MBC2 RAM lives inside the mapper and fits in one sector; the header
        // RAM-size byte is 0 on these carts and must not be trusted.
        if (!is_mbc2(cart_mbc_type)) begin
            if (cart_ram_size >= RAM_SIZE_128K) begin
                last_lba = LBA_W'(255);
            end else begin
                case (cart_ram_size)
                    RAM_SIZE_2K:  last_lba = LBA_W'(3);
                    RAM_SIZE_8K:  last_lba = LBA_W'(15);
                    RAM_SIZE_32K: last_lba = LBA_W'(63);
                    default:      ram_present = 1'b0;
                endcase
            end
        end
        supported = is_battery_mbc(cart_mbc_type) & ram_present;
    end

endmodule

// File: rtl/cram_backup_ctrl.sv
// cram_backup_ctrl: sequences save/load of battery-backed cart RAM to/from
// host sectors and arbitrates the single cart RAM port between the Game Boy
// (MBC) side and the host sector buffer.
//   clk_sys, reset_n                  : clock, async active-low reset
//   cart_mbc_type/ram_size/loaded     : cartridge header and download status
//   gb_ram_*  , gb_stall              : MBC RAM access path and pause request
//   mem_*                             : cart RAM BRAM port (1-cycle read latency)
//   bk_load_req/bk_save_req           : single-cycle transfer requests
//   sd_lba/sd_rd/sd_wr/sd_ack/sd_buff*: host sector interface
//   bk_busy, sav_pending              : status
//   dbg_state                         : current sequencer state (bk_state_t)
// Build option: CRAM_BACKUP_AUTOLOAD_EN - a rising cart_loaded starts a load.
//
// Sector handshake: sd_rd (load) or sd_wr (save) is a level request raised on
// entry to REQ with sd_lba stable. The host takes the sector by raising
// sd_ack, which drops the request; while sd_ack is high the host owns the RAM
// port. Dropping sd_ack ends the sector. One request per sector.
module cram_backup_ctrl
    import gbc_bk_pkg::*;
#(
    parameter int LBA_W  = 8,
    parameter int SECT_W = $clog2(SECTOR_BYTES)
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [7:0]              cart_mbc_type,
    input  logic [7:0]              cart_ram_size,
    input  logic                    cart_loaded,
    input  logic [LBA_W+SECT_W-1:0] gb_ram_addr,
    input  logic                    gb_ram_rd,
    input  logic                    gb_ram_wr,
    input  logic [7:0]              gb_ram_di,
    output logic [7:0]              gb_ram_do,
    output logic                    gb_stall,
    output logic [LBA_W+SECT_W-1:0] mem_addr,
    output logic                    mem_we,
    output logic [7:0]              mem_di,
    input  logic [7:0]              mem_do,
    input  logic                    bk_load_req,
    input  logic                    bk_save_req,
    output logic [LBA_W-1:0]        sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    input  logic [SECT_W-1:0]       sd_buff_addr,
    input  logic                    sd_buff_wr,
    input  logic [7:0]              sd_buff_dout,
    output logic [7:0]              sd_buff_din,
    output logic                    bk_busy,
    output logic                    sav_pending,
    output logic [1:0]              dbg_state
);

    bk_state_t        state;
    logic             dir;        // 1 = load (host -> RAM), 0 = save
    logic             sd_ack_q;
    logic [LBA_W-1:0] last_lba;
    logic             supported;
    logic             autoload;
    logic             start_req;
    logic             start_dir;
    logic             ack_rise;
    logic             ack_fall;
    logic             gb_wr_ok;

    cram_backup_size_decode #(
        .LBA_W (LBA_W)
    ) u_size_decode (
        .cart_mbc_type (cart_mbc_type),
        .cart_ram_size (cart_ram_size),
        .last_lba      (last_lba),
        .supported     (supported)
    );

`ifdef CRAM_BACKUP_AUTOLOAD_EN
    logic cart_loaded_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cart_loaded_q <= 1'b0;
        end else begin
            cart_loaded_q <= cart_loaded;
        end
    end

    assign autoload = cart_loaded & ~cart_loaded_q;
`else
    logic unused_cart_loaded;

    assign unused_cart_loaded = cart_loaded;
    assign autoload           = 1'b0;
`endif

    // Load wins over save when both arrive together.
    assign start_req = (state == ST_IDLE) & supported & (bk_load_req | bk_save_req | autoload);
    assign start_dir = bk_load_req | autoload;
    assign ack_rise  = sd_ack & ~sd_ack_q;
    assign ack_fall  = ~sd_ack & sd_ack_q;

    // bk_busy is registered, so a GB access in the cycle a request is accepted
    // still completes; from the next cycle on GB accesses are held off.
    assign gb_stall = bk_busy & (gb_ram_rd | gb_ram_wr);
    assign gb_wr_ok = gb_ram_wr & ~gb_stall;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            dir         <= 1'b0;
            sd_lba      <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            bk_busy     <= 1'b0;
            sd_ack_q    <= 1'b0;
            sav_pending <= 1'b0;
        end else begin
            sd_ack_q <= sd_ack;

            // Starting a transfer makes RAM and image consistent, so it wins
            // over a GB write landing in the same cycle.
            if (start_req) begin
                sav_pending <= 1'b0;
            end else if (gb_wr_ok & supported) begin
                sav_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state   <= ST_REQ;
                        dir     <= start_dir;
                        sd_lba  <= '0;
                        sd_rd   <= start_dir;
                        sd_wr   <= ~start_dir;
                        bk_busy <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (ack_fall) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (sd_lba == last_lba) begin
                        state   <= ST_IDLE;
                        bk_busy <= 1'b0;
                    end else begin
                        sd_lba <= sd_lba + LBA_W'(1);
                        sd_rd  <= dir;
                        sd_wr  <= ~dir;
                        state  <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The host owns the port whenever it holds sd_ack. dir is cleared by
    // reset, so an aborted load cannot keep writing RAM.
    always_comb begin
        if (sd_ack) begin
            mem_addr = {sd_lba, sd_buff_addr};
            mem_we   = sd_buff_wr & dir;
            mem_di   = sd_buff_dout;
        end else begin
            mem_addr = gb_ram_addr;
            mem_we   = gb_wr_ok;
            mem_di   = gb_ram_di;
        end
    end

    assign sd_buff_din = mem_do;
    assign gb_ram_do   = mem_do;
    assign dbg_state   = state;

endmodule

// File: tb/tb_cram_backup_ctrl.sv
module tb_cram_backup_ctrl;

    localparam int AW = 17;

    // ---------------- clock / reset / signals ----------------
    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    cart_mbc_type;
    logic [7:0]    cart_ram_size;
    logic          cart_loaded;
    logic [AW-1:0] gb_ram_addr;
    logic          gb_ram_rd;
    logic          gb_ram_wr;
    logic [7:0]    gb_ram_di;
    logic [7:0]    gb_ram_do;
    logic          gb_stall;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_di;
    logic [7:0]    mem_do;
    logic          bk_load_req;
    logic          bk_save_req;
    logic [7:0]    sd_lba;
    logic          sd_rd;
    logic          sd_wr;
    logic          sd_ack;
    logic [8:0]    sd_buff_addr;
    logic          sd_buff_wr;
    logic [7:0]    sd_buff_dout;
    logic [7:0]    sd_buff_din;
    logic          bk_busy;
    logic          sav_pending;
    logic [1:0]    dbg_state;

    always #5 clk_sys = ~clk_sys;

    cram_backup_ctrl dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .cart_mbc_type (cart_mbc_type),
        .cart_ram_size (cart_ram_size),
        .cart_loaded   (cart_loaded),
        .gb_ram_addr   (gb_ram_addr),
        .gb_ram_rd     (gb_ram_rd),
        .gb_ram_wr     (gb_ram_wr),
        .gb_ram_di     (gb_ram_di),
        .gb_ram_do     (gb_ram_do),
        .gb_stall      (gb_stall),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_di        (mem_di),
        .mem_do        (mem_do),
        .bk_load_req   (bk_load_req),
        .bk_save_req   (bk_save_req),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_dout  (sd_buff_dout),
        .sd_buff_din   (sd_buff_din),
        .bk_busy       (bk_busy),
        .sav_pending   (sav_pending),
        .dbg_state     (dbg_state)
    );

    // Cart RAM BRAM: synchronous write, 1-cycle registered read.
    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_di;
        mem_do <= ram[mem_addr];
    end

    // ---------------- behavioural model ----------------
    int         checks = 0;
    int         failures = 0;
    logic       check_en = 1'b0;
    logic       exp_busy = 1'b0;
    logic       exp_pending = 1'b0;
    logic       cur_dir = 1'b0;
    logic [7:0] cur_lba = 8'd0;
    logic [7:0] exp_q[$];
    int         sectors_seen = 0;
    logic [7:0] cap_din = 8'd0;

    function automatic logic [7:0] save_pat(input logic [16:0] a);
        return a[7:0] ^ a[16:9];
    endfunction

    function automatic logic [7:0] load_pat(input logic [8:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic bit m_mbc2();
        return (cart_mbc_type == 8'h05) || (cart_mbc_type == 8'h06);
    endfunction

    function automatic bit m_supported();
        bit batt;
        batt = cart_mbc_type inside {8'h03, 8'h06, 8'h09, 8'h0D, 8'h10,
                                     8'h13, 8'h1B, 8'h1E, 8'h22, 8'hFF};
        return batt && (m_mbc2() || cart_ram_size != 8'd0);
    endfunction

    // Sector count from RAM bytes: 2K, 8K, 32K, 128K over 512-byte sectors.
    function automatic int m_last();
        if (m_mbc2()) return 0;
        if (cart_ram_size == 8'd1) return (2048 / 512) - 1;
        if (cart_ram_size == 8'd2) return (8192 / 512) - 1;
        if (cart_ram_size == 8'd3) return (32768 / 512) - 1;
        return (131072 / 512) - 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_sys) begin
        if (check_en) begin
            check("busy", bk_busy, exp_busy);
            check("pending", sav_pending, exp_pending);
            check("stall", gb_stall, exp_busy && (gb_ram_rd || gb_ram_wr));
            if (!exp_busy) check("idle_no_req", {sd_rd, sd_wr}, 2'b00);
            if (sd_ack) begin
                check("host_addr", mem_addr, {cur_lba, sd_buff_addr});
                check("host_we", mem_we, sd_buff_wr && cur_dir);
                if (sd_buff_wr && cur_dir) check("host_di", mem_di, sd_buff_dout);
            end else begin
                check("gb_addr", mem_addr, gb_ram_addr);
                check("gb_we", mem_we, gb_ram_wr && !exp_busy);
                if (gb_ram_wr && !exp_busy) check("gb_di", mem_di, gb_ram_di);
                check("gb_do", gb_ram_do, mem_do);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic gb_write(input logic [AW-1:0] addr, input logic [7:0] data);
        @(posedge clk_sys); #1;
        gb_ram_addr = addr;
        gb_ram_di   = data;
        gb_ram_wr   = 1'b1;
        @(posedge clk_sys); #1;
        gb_ram_wr = 1'b0;
        if (!exp_busy && m_supported()) exp_pending = 1'b1;
    endtask

    task automatic start_req(input bit load, input bit save, input bit gb_too);
        @(posedge clk_sys); #1;
        bk_load_req = load;
        bk_save_req = save;
        if (gb_too) begin
            gb_ram_addr = 17'h1FFFF;
            gb_ram_di   = 8'h77;
            gb_ram_wr   = 1'b1;
        end
        @(posedge clk_sys); #1;
        bk_load_req = 1'b0;
        bk_save_req = 1'b0;
        gb_ram_wr   = 1'b0;
        if (m_supported() && !exp_busy) begin
            exp_busy    = 1'b1;
            exp_pending = 1'b0;
            cur_dir     = load;
            exp_q.delete();
            for (int i = 0; i <= m_last(); i++) exp_q.push_back(8'(i));
        end else if (gb_too && m_supported()) begin
            exp_pending = 1'b1;
        end
    endtask

    task automatic wait_sector_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk_sys);
            seen = sd_rd | sd_wr;
        end
        check("sector_req_seen", seen, 1);
    endtask

    task automatic serve_sector(input int nbytes, input bit gb_poke);
        logic [7:0] lba;
        bit         seen;
        if (exp_q.size() == 0) begin
            check("sector_expected", 0, 1);
            return;
        end
        lba = exp_q.pop_front();
        wait_sector_req(seen);
        if (!seen) return;
        check("sector_lba", sd_lba, lba);
        check("sector_rd", sd_rd, cur_dir);
        check("sector_wr", sd_wr, !cur_dir);
        @(posedge clk_sys); #1;
        if (gb_poke) begin
            gb_ram_addr = 17'h1F000;
            gb_ram_di   = 8'hC3;
            gb_ram_wr   = 1'b1;
            gb_ram_rd   = 1'b1;
        end
        @(posedge clk_sys); #1;
        sd_ack  = 1'b1;
        cur_lba = lba;
        for (int a = 0; a <= nbytes; a++) begin
            if (a < nbytes) begin
                sd_buff_addr = 9'(a);
                sd_buff_wr   = cur_dir;
                sd_buff_dout = load_pat(9'(a));
            end else begin
                sd_buff_wr = 1'b0;
            end
            @(negedge clk_sys);
            if (!cur_dir && a > 0) begin
                check("save_din", sd_buff_din, save_pat({lba, 9'(a - 1)}));
                if (lba == 8'd3 && a == 17) cap_din = sd_buff_din;
            end
            @(posedge clk_sys); #1;
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        gb_ram_wr  = 1'b0;
        gb_ram_rd  = 1'b0;
        sectors_seen++;
        if (exp_q.size() == 0) begin
            @(posedge clk_sys);
            @(posedge clk_sys); #1;
            exp_busy = 1'b0;
        end
    endtask

    task automatic expect_quiet(input int n, input string name);
        bit act = 1'b0;
        repeat (n) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr || bk_busy) act = 1'b1;
        end
        check(name, act, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  bad;
        bit  seen;
        logic [7:0] lba5;
        cart_mbc_type = 8'h00;
        cart_ram_size = 8'h00;
        cart_loaded   = 1'b0;
        gb_ram_addr   = '0;
        gb_ram_rd     = 1'b0;
        gb_ram_wr     = 1'b0;
        gb_ram_di     = 8'h00;
        bk_load_req   = 1'b0;
        bk_save_req   = 1'b0;
        sd_ack        = 1'b0;
        sd_buff_addr  = '0;
        sd_buff_wr    = 1'b0;
        sd_buff_dout  = 8'h00;
        for (int i = 0; i < (1 << AW); i++) ram[i] = save_pat(17'(i));

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_sd_rd", sd_rd, 0);
        check("rst_sd_wr", sd_wr, 0);
        check("rst_sd_lba", sd_lba, 0);
        check("rst_busy", bk_busy, 0);
        check("rst_pending", sav_pending, 0);
        check("rst_stall", gb_stall, 0);
        check("rst_mem_we", mem_we, 0);
        @(posedge clk_sys); #1;
        reset_n  = 1'b1;
        check_en = 1'b1;

        // Save: type 0x03, 8K RAM -> 16 sectors; GB write coincident with request.
        cart_mbc_type = 8'h03;
        cart_ram_size = 8'h02;
        gb_write(17'h1FFF0, 8'h11);
        check("pending_set", sav_pending, 1);
        start_req(1'b0, 1'b1, 1'b1);
        sectors_seen = 0;
        for (int s = 0; s < 16; s++) serve_sector(512, s == 2);
        check("save_sector_count", sectors_seen, 16);
        check("save_final_lba", sd_lba, 8'd15);
        check("save_literal_din", cap_din, 8'h13);
        check("save_busy_done", bk_busy, 0);
        check("save_pending_clr", sav_pending, 0);
        check("stalled_not_written", ram[17'h1F000], 8'hF8);
        check("coincident_gb_wr", ram[17'h1FFFF], 8'h77);
        gb_write(17'h1F000, 8'hC3);
        check("gb_after_busy", ram[17'h1F000], 8'hC3);

        // Load: MBC2 type 0x06 -> one sector; load and save together -> load.
        cart_mbc_type = 8'h06;
        cart_ram_size = 8'h00;
        gb_write(17'h00100, 8'hEE);
        check("mbc2_pending_set", sav_pending, 1);
        start_req(1'b1, 1'b1, 1'b0);
        check("simul_sd_rd", sd_rd, 1);
        check("simul_sd_wr", sd_wr, 0);
        sectors_seen = 0;
        serve_sector(512, 1'b0);
        expect_quiet(30, "mbc2_single_sector");
        check("mbc2_sector_count", sectors_seen, 1);
        check("mbc2_pending_clr", sav_pending, 0);
        bad = 0;
        for (int a = 0; a < 512; a++) if (ram[a] !== load_pat(9'(a))) bad++;
        check("load_data_bad", bad, 0);
        check("load_lit_0", ram[0], 8'hA5);
        check("load_lit_511", ram[511], 8'h5A);
        check("load_no_spill", ram[512], 8'h01);

        // Unsupported type 0x01: no transfer, GB write does not mark pending.
        cart_mbc_type = 8'h01;
        cart_ram_size = 8'h02;
        start_req(1'b0, 1'b1, 1'b0);
        expect_quiet(30, "unsup_quiet");
        gb_write(17'h00200, 8'h42);
        check("unsup_pending", sav_pending, 0);
        check("unsup_gb_written", ram[17'h00200], 8'h42);

        // Reset during XFER of sector 5 of a 64-sector load.
        cart_mbc_type = 8'h03;
        cart_ram_size = 8'h03;
        start_req(1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) serve_sector(4, 1'b0);
        lba5 = exp_q.pop_front();
        wait_sector_req(seen);
        check("rst5_lba", sd_lba, lba5);
        @(posedge clk_sys); #1;
        sd_ack       = 1'b1;
        cur_lba      = lba5;
        sd_buff_wr   = 1'b1;
        sd_buff_dout = 8'h99;
        sd_buff_addr = 9'd0;
        repeat (3) begin
            @(posedge clk_sys); #1;
            sd_buff_addr = sd_buff_addr + 9'd1;
        end
        check_en     = 1'b0;
        reset_n      = 1'b0;
        sd_buff_addr = 9'h010;
        @(negedge clk_sys);
        check("rst_mid_sd_rd", sd_rd, 0);
        check("rst_mid_busy", bk_busy, 0);
        check("rst_mid_we", mem_we, 0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("post_rst_we", mem_we, 0);
        check("post_rst_sd_rd", sd_rd, 0);
        @(posedge clk_sys); #1;
        sd_ack      = 1'b0;
        sd_buff_wr  = 1'b0;
        exp_busy    = 1'b0;
        exp_pending = 1'b0;
        cur_dir     = 1'b0;
        exp_q.delete();
        check_en    = 1'b1;
        expect_quiet(30, "rst_abort_quiet");
        check("rst_abort_ram", ram[{8'd5, 9'h010}], 8'h15);
        check("rst_pre_written", ram[{8'd5, 9'h001}], 8'h99);

        // Cart-loaded edge on type 0x1B, 32K RAM.
        cart_mbc_type = 8'h1B;
        cart_ram_size = 8'h03;
        @(posedge clk_sys); #1;
        cart_loaded = 1'b1;
        @(posedge clk_sys); #1;
`ifdef CRAM_BACKUP_AUTOLOAD_EN
        exp_busy    = 1'b1;
        exp_pending = 1'b0;
        cur_dir     = 1'b1;
        exp_q.delete();
        for (int i = 0; i <= m_last(); i++) exp_q.push_back(8'(i));
        sectors_seen = 0;
        for (int s = 0; s < 64; s++) serve_sector(2, 1'b0);
        check("autoload_sector_count", sectors_seen, 64);
        check("autoload_final_lba", sd_lba, 8'd63);
        expect_quiet(20, "autoload_done_quiet");
`else
        expect_quiet(30, "autoload_off_quiet");
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
